serial_byte_rx: RTL and testbench
=================================

// Module: serial_byte_rx
//
// PURPOSE
// Serial-to-parallel receiver that turns a 1-bit framed line (rx_in) into
// DATA_W-bit words with a valid/ready output. It is the receive end of the
// single-bit serial link whose transmit side drives a one-bit line.
// Bit timing is oversampled, and received words are buffered in a small FIFO
// so that a stalled consumer does not lose back-to-back frames.
//
// PARAMETERS
// CLKS_PER_BIT  4   clk cycles per serial bit; must be even and >= 2
// DATA_W        8   data bits per frame, sent LSB first
// FIFO_DEPTH    4   output buffer entries; must be a power of 2 and >= 2
//
// PORTS
// clk           in   1                    clock
// rst_n         in   1                    reset, asynchronous, active-low
// rx_in         in   1                    serial line; idle level is 1
// out_data      out  DATA_W               FIFO head word
// out_valid     out  1                    FIFO not empty
// out_ready     in   1                    consumer accepts out_data
// frame_err     out  1                    1-cycle pulse: stop bit sampled as 0
// overflow      out  1                    sticky: a word was dropped because the FIFO was full
// clr_overflow  in   1                    synchronous clear of overflow
// fifo_count    out  $clog2(FIFO_DEPTH)+1 number of entries held
//
// BEHAVIOUR
// - Reset values: out_valid=0, out_data=0, frame_err=0, overflow=0,
//   fifo_count=0, FSM=IDLE, synchronizer flops=1.
// - rx_in passes through a 2-flop synchronizer (rx_s). All sampling uses rx_s.
// - Frame: start bit (0), then DATA_W data bits (LSB first), then stop bit (1).
// - FSM states: IDLE, START, DATA, STOP. cnt is the bit-timer; idx is the bit index.
//   - IDLE: rx_s==0 -> START, cnt=0.
//   - START: when cnt==CLKS_PER_BIT/2-1, sample rx_s.
//     - 0 -> DATA, cnt=0, idx=0.
//     - 1 -> IDLE (glitch rejected, no output).
//   - DATA: when cnt==CLKS_PER_BIT-1, shift rx_s into bit idx and set cnt=0.
//     After bit DATA_W-1 -> STOP.
//   - STOP: when cnt==CLKS_PER_BIT-1, sample rx_s, then -> IDLE.
//     - 1: push the word.
//     - 0: pulse frame_err for 1 cycle and discard the word.
// - Sample points are therefore mid-bit for every bit.
// - Push latency: the word appears at out_data, with out_valid=1, on the
//   cycle after the stop-bit sample if the FIFO was empty.
// - Pop: out_valid && out_ready in a cycle. The head advances the next cycle.
// - Push into a full FIFO with no pop in the same cycle: drop the word and set
//   overflow=1. The FIFO contents are unchanged.
// - Push and pop in the same cycle while full: both happen, overflow is not set,
//   and count is unchanged.
// - Push and pop in the same cycle while empty: not possible, because a push is
//   not visible until the next cycle.
// - clr_overflow in the same cycle as a new overflow event: the set wins.
// - Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
// - out_data holds its value while out_valid=1 and out_ready=0. When the FIFO
//   is empty, out_data holds its last value.
// - rst_n asserted mid-frame: the partial word is discarded, the FIFO is emptied,
//   and the FSM goes to IDLE. The next frame after release is received normally.
// - A stop-bit failure does not stall the receiver: the next falling edge
//   starts a new frame.
//
// TESTING (CLKS_PER_BIT=4, DATA_W=8, FIFO_DEPTH=4)
// 1. Send 0xA5 with out_ready=1 -> one beat with out_data=0xA5; frame_err=0;
//    fifo_count returns to 0.
// 2. Hold rx_in low for 1 cycle, then high -> FSM returns to IDLE; no
//    out_valid and no frame_err.
// 3. Send 0x3C with the stop bit forced to 0 -> frame_err high for exactly
//    1 cycle; fifo_count stays 0.
// 4. out_ready=0, send 0x01..0x05 -> fifo_count=4 and overflow=1. Then raise
//    out_ready -> read 0x01,0x02,0x03,0x04 in order; 0x05 is lost.
// 5. FIFO full; pulse out_ready on the stop-sample push cycle of 0x06 ->
//    overflow stays 0; the tail entry is 0x06.
// 6. Assert rst_n after data bit 3 of 0x77 -> all outputs return to their reset
//    values. Then send 0x81 -> out_data=0x81.

Source files
------------

// File: rtl/serial_byte_rx.sv
// Oversampled serial-to-parallel receiver: 2-flop synchronizer, framing FSM with
// mid-bit sampling, and a small output FIFO with valid/ready and sticky overflow.
module serial_byte_rx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_in,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          clr_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic              rx_meta, rx_s;
  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              push, ferr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      shreg     <= shreg_nxt;
      frame_err <= ferr_nxt;
    end
  end

  // START samples at half a bit so every later sample lands mid-bit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    push      = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (cnt == HALF_CNT) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST_CNT) begin
          cnt_nxt        = '0;
          shreg_nxt[idx] = rx_s;
          if (idx == LAST_IDX) state_nxt = STOP;
          else                 idx_nxt   = idx + 1'b1;
        end
      end
      STOP: begin
        if (cnt == LAST_CNT) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          if (rx_s) push     = 1'b1;
          else      ferr_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr, rptr, rptr_nxt;
  logic [AW:0]       count_nxt;
  logic              full, pop, do_write, ovf_evt;
  logic [DATA_W-1:0] head_nxt;

  assign out_valid = (fifo_count != '0);
  assign full      = (fifo_count == FULL_CNT);
  assign pop       = out_valid && out_ready;
  assign do_write  = push && (!full || pop);
  assign ovf_evt   = push && full && !pop;
  assign rptr_nxt  = pop ? rptr + 1'b1 : rptr;

  always_comb begin
    count_nxt = fifo_count;
    case ({do_write, pop})
      2'b10:   count_nxt = fifo_count + 1'b1;
      2'b01:   count_nxt = fifo_count - 1'b1;
      default: count_nxt = fifo_count;
    endcase
  end

  // out_data is registered so it holds the last word once the FIFO drains;
  // a word being written this cycle may become the new head immediately.
  assign head_nxt = (do_write && (rptr_nxt == wptr)) ? shreg : mem[rptr_nxt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      out_data   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (do_write) begin
        mem[wptr] <= shreg;
        wptr      <= wptr + 1'b1;
      end
      rptr       <= rptr_nxt;
      fifo_count <= count_nxt;
      if (count_nxt != '0) out_data <= head_nxt;
      if (ovf_evt)           overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_byte_rx.sv
// Directed bench for serial_byte_rx: framing, glitch rejection, frame errors,
// FIFO overflow, simultaneous push/pop when full, and mid-frame reset.
module tb_serial_byte_rx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_in = 1'b1;
  logic       out_ready = 1'b0;
  logic       clr_overflow = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, frame_err, overflow;
  logic [2:0] fifo_count;

  int errors = 0;
  int checks = 0;
  logic [7:0] got_q [$];
  int fe_cycles = 0;

  always #5 clk = ~clk;

  serial_byte_rx #(.CLKS_PER_BIT(4), .DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .frame_err(frame_err), .overflow(overflow), .clr_overflow(clr_overflow),
    .fifo_count(fifo_count)
  );

  // Inputs change 1 time unit after posedge, so negedge sees settled handshakes.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got_q.push_back(out_data);
    if (frame_err) fe_cycles++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Leaves the bench one cycle before the stop-bit sampling edge.
  task automatic send_bits(input logic [7:0] b, input logic stop);
    rx_in = 1'b0; tick(4);
    for (int i = 0; i < 8; i++) begin rx_in = b[i]; tick(4); end
    rx_in = stop; tick(4);
  endtask

  task automatic finish_frame();
    rx_in = 1'b1; tick(6);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(2);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", out_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    rst_n = 1'b1; tick(3);
  endtask

  task automatic test_single_frame();
    int n0, f0;
    n0 = got_q.size(); f0 = fe_cycles;
    out_ready = 1'b1;
    send_bits(8'hA5, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin errors++; $display("FAIL latency_push got=%b/%h exp=1/a5", out_valid, out_data); end
    finish_frame();
    checks++; if (got_q.size() !== n0 + 1) begin errors++; $display("FAIL a5_beats got=%0d exp=%0d", got_q.size() - n0, 1); end
    else begin
      checks++; if (got_q[n0] !== 8'hA5) begin errors++; $display("FAIL a5_data got=%h exp=a5", got_q[n0]); end
    end
    checks++; if (fe_cycles !== f0) begin errors++; $display("FAIL a5_ferr got=%0d exp=0", fe_cycles - f0); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL a5_count got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_glitch();
    int n0, f0;
    n0 = got_q.size(); f0 = fe_cycles;
    rx_in = 1'b0; tick();
    rx_in = 1'b1; tick(12);
    checks++; if (got_q.size() !== n0 || out_valid !== 1'b0) begin errors++; $display("FAIL glitch_out beats=%0d valid=%b exp=0/0", got_q.size() - n0, out_valid); end
    checks++; if (fe_cycles !== f0) begin errors++; $display("FAIL glitch_ferr got=%0d exp=0", fe_cycles - f0); end
  endtask

  task automatic test_frame_err();
    int n0, f0;
    n0 = got_q.size(); f0 = fe_cycles;
    out_ready = 1'b1;
    send_bits(8'h3C, 1'b0);
    finish_frame();
    checks++; if (fe_cycles - f0 !== 1) begin errors++; $display("FAIL ferr_pulse got=%0d cycles exp=1", fe_cycles - f0); end
    checks++; if (fifo_count !== 3'd0 || got_q.size() !== n0) begin errors++; $display("FAIL ferr_drop count=%0d beats=%0d exp=0/0", fifo_count, got_q.size() - n0); end
  endtask

  task automatic test_overflow();
    int n0;
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin send_bits(8'(i), 1'b1); finish_frame(); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", fifo_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h01) begin errors++; $display("FAIL ovf_head got=%b/%h exp=1/01", out_valid, out_data); end
    n0 = got_q.size();
    out_ready = 1'b1; tick(6);
    checks++; if (got_q.size() !== n0 + 4) begin errors++; $display("FAIL ovf_beats got=%0d exp=4", got_q.size() - n0); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (got_q[n0+i] !== 8'(i + 1)) begin errors++; $display("FAIL ovf_order[%0d] got=%h exp=%h", i, got_q[n0+i], 8'(i + 1)); end
      end
    end
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h04) begin errors++; $display("FAIL empty_hold got=%b/%h exp=0/04", out_valid, out_data); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_full_push_pop();
    int n0;
    logic [7:0] exp [4];
    exp = '{8'h02, 8'h03, 8'h04, 8'h06};
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin send_bits(8'(i), 1'b1); finish_frame(); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_pre got=%0d exp=4", fifo_count); end
    n0 = got_q.size();
    send_bits(8'h06, 1'b1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    finish_frame();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pp_ovf got=%b exp=0", overflow); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL pp_count got=%0d exp=4", fifo_count); end
    checks++; if (got_q.size() !== n0 + 1 || got_q[got_q.size()-1] !== 8'h01) begin errors++; $display("FAIL pp_pop beats=%0d exp=1 of 01", got_q.size() - n0); end
    n0 = got_q.size();
    out_ready = 1'b1; tick(6);
    checks++; if (got_q.size() !== n0 + 4) begin errors++; $display("FAIL pp_drain got=%0d exp=4", got_q.size() - n0); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (got_q[n0+i] !== exp[i]) begin errors++; $display("FAIL pp_order[%0d] got=%h exp=%h", i, got_q[n0+i], exp[i]); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int n0;
    logic [7:0] b;
    b = 8'h77;
    out_ready = 1'b0;
    send_bits(8'h5A, 1'b1); finish_frame();
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL mid_pre got=%0d exp=1", fifo_count); end
    rx_in = 1'b0; tick(4);
    for (int i = 0; i < 4; i++) begin rx_in = b[i]; tick(4); end
    rx_in = 1'b1; rst_n = 1'b0; tick(2);
    checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL mid_empty got=%b/%0d exp=0/0", out_valid, fifo_count); end
    checks++; if (out_data !== 8'h00 || frame_err !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL mid_outs got=%h/%b/%b exp=00/0/0", out_data, frame_err, overflow); end
    rst_n = 1'b1; tick(3);
    n0 = got_q.size();
    out_ready = 1'b1;
    send_bits(8'h81, 1'b1); finish_frame();
    checks++; if (got_q.size() !== n0 + 1 || got_q[got_q.size()-1] !== 8'h81) begin errors++; $display("FAIL mid_next beats=%0d exp=1 of 81", got_q.size() - n0); end
    checks++; if (out_data !== 8'h81) begin errors++; $display("FAIL mid_data got=%h exp=81", out_data); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_glitch();
    test_frame_err();
    test_overflow();
    test_full_push_pop();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
